bcd_to_binary: RTL and testbench



---
 rtl/bcd_to_binary.sv | 123 ++++++++++++
 tb/tb_bcd_to_binary.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// A start/busy/done handshake sequences conversions; invalid digits finish at once with err set.
module bcd_to_binary #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  CLOCK_50,
   input  logic                  RESETN,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err,
   output logic [1:0]            dbg_state
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int W_W   = 2 * BCD_W;
   localparam int ITER  = BCD_W;
   localparam int CNT_W = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Handshake: start is taken only while busy=0; done pulses for one cycle and
   // bin_out/err are valid from that cycle until the next done pulse.
   state_t             state_q, state_d;
   logic [W_W-1:0]     w_q, w_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               in_bad;
   logic [W_W-1:0]     w_shift;

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // Shift right, then pull every BCD digit that reached 8 or more back down by 3.
   always_comb begin
      w_shift = w_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_shift[BCD_W + 4*i +: 4] >= 4'd8)
            w_shift[BCD_W + 4*i +: 4] = w_shift[BCD_W + 4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (in_bad) begin
                  bin_d   = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  w_d     = {bcd_in, {BCD_W{1'b0}}};
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            w_d   = w_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) begin
               bin_d   = w_shift[BIN_W-1:0];
               err_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESETN) begin
         state_q <= IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign bin_out   = bin_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed handshake cases plus random codes
// compared against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

   localparam int DIGITS = 2;
   localparam int BIN_W  = 7;
   localparam int LAT    = 4 * DIGITS + 1;

   logic                 clk;
   logic                 resetn;
   logic                 start;
   logic [4*DIGITS-1:0]  bcd_in;
   logic                 busy;
   logic                 done;
   logic [BIN_W-1:0]     bin_out;
   logic                 err;
   logic [1:0]           dbg_state;

   int total_checks;
   int passed_checks;

   bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .CLOCK_50  (clk),
      .RESETN    (resetn),
      .start     (start),
      .bcd_in    (bcd_in),
      .busy      (busy),
      .done      (done),
      .bin_out   (bin_out),
      .err       (err),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Reference model: decimal value of the digits, or invalid if any digit exceeds 9.
   function automatic void model(input logic [4*DIGITS-1:0] code, output int value, output bit bad);
      value = 0;
      bad   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         int d;
         d = int'((code >> (4 * i)) & 4'hF);
         if (d > 9) bad = 1'b1;
         value = value * 10 + d;
      end
      if (bad) value = 0;
   endfunction

   // Full conversion with cycle-by-cycle handshake checks; optionally rewrites bcd_in mid-flight.
   task automatic convert(input logic [4*DIGITS-1:0] code, input int mut_at,
                          input logic [4*DIGITS-1:0] mut_val);
      int  exp_v;
      bit  bad;
      model(code, exp_v, bad);
      start  = 1'b1;
      bcd_in = code;
      tick();
      start = 1'b0;
      if (bad) begin
         check("inv_busy", busy, 1);
         check("inv_done", done, 1);
         check("inv_err", err, 1);
         check("inv_bin", bin_out, 0);
         tick();
         check("inv_busy_low", busy, 0);
         check("inv_done_low", done, 0);
      end else begin
         for (int k = 1; k <= LAT; k++) begin
            if (k == mut_at) bcd_in = mut_val;
            check("conv_busy", busy, 1);
            check("conv_done", done, (k == LAT) ? 1 : 0);
            if (k == LAT) begin
               check("conv_bin", bin_out, exp_v);
               check("conv_err", err, 0);
            end
            tick();
         end
         check("conv_busy_low", busy, 0);
         check("conv_done_low", done, 0);
      end
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      resetn = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bin", bin_out, 0);
      check("rst_err", err, 0);
      resetn = 1'b1;
      tick();

      convert(8'h42, 0, 8'h00);
      for (int k = 0; k < 10; k++) tick();
      check("hold_42", bin_out, 42);
      check("hold_42_done", done, 0);

      convert(8'h99, 0, 8'h00);
      convert(8'h00, 0, 8'h00);

      // Invalid input, then a valid one must clear err.
      convert(8'hA5, 0, 8'h00);
      convert(8'h17, 0, 8'h00);

      // start held high across a conversion: exactly one done, then the next start at T+10.
      start  = 1'b1;
      bcd_in = 8'h42;
      tick();
      bcd_in = 8'h13;
      for (int k = 1; k <= LAT; k++) begin
         check("held_done_a", done, (k == LAT) ? 1 : 0);
         if (k == LAT) check("held_bin_a", bin_out, 42);
         tick();
      end
      check("held_idle", busy, 0);
      tick();
      start = 1'b0;
      for (int k = 11; k <= 10 + LAT; k++) begin
         check("held_done_b", done, (k == 10 + LAT) ? 1 : 0);
         if (k == 10 + LAT) check("held_bin_b", bin_out, 13);
         tick();
      end

      // Input changed mid-conversion is ignored.
      convert(8'h88, 3, 8'h11);

      // Reset in the middle of a conversion abandons it without a done pulse.
      start  = 1'b1;
      bcd_in = 8'h56;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mrst_busy", busy, 0);
      check("mrst_bin", bin_out, 0);
      check("mrst_err", err, 0);
      check("mrst_done", done, 0);
      for (int k = 0; k < 2 * LAT; k++) begin
         check("mrst_no_done", done, 0);
         tick();
      end
      convert(8'h56, 0, 8'h00);

      // All valid codes, in a randomly rotated order.
      begin
         int base;
         base = int'($urandom_range(0, 99));
         for (int n = 0; n < 100; n++) begin
            int v;
            v = (base + n) % 100;
            convert(8'((v / 10) * 16 + (v % 10)), 0, 8'h00);
         end
      end

      // Random raw 8-bit codes, valid and invalid mixed, with random idle gaps.
      for (int n = 0; n < 40; n++) begin
         convert(8'($urandom_range(0, 255)), 0, 8'h00);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
